// File: rtl/sat_init_pkg.sv
// rtl/sat_init_pkg.sv - shared states and next-enabled-engine helper for clause_init_loader
package sat_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } init_state_e;

    localparam int MAX_ENG = 32;
    localparam int SEL_W   = 5;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } next_sel_t;

    // Lowest set bit of mask strictly above idx; idx = -1 searches from bit 0.
    function automatic next_sel_t next_enabled(input logic [MAX_ENG-1:0] mask, input int idx);
        next_sel_t r;
        r = '0;
        for (int i = MAX_ENG - 1; i >= 0; i--) begin
            if (mask[i] && (i > idx)) begin
                r.found = 1'b1;
                r.idx   = SEL_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_next_sel.sv
// rtl/prio_next_sel.sv - next enabled engine above the current one (or lowest when from_start_i)
module prio_next_sel
    import sat_init_pkg::*;
#(
    parameter int N_ENG = 4,
    parameter int IDXW  = 2
) (
    input  logic [N_ENG-1:0] mask_i,
    input  logic [IDXW-1:0]  cur_i,
    input  logic             from_start_i,
    output logic             found_o,
    output logic [IDXW-1:0]  idx_o
);
    logic [MAX_ENG-1:0] mask_ext;
    next_sel_t          sel;

    always_comb begin
        mask_ext = MAX_ENG'(mask_i);
        sel      = next_enabled(mask_ext, from_start_i ? -1 : int'(cur_i));
        found_o  = sel.found;
        idx_o    = IDXW'(sel.idx);
    end

endmodule

// File: rtl/clause_init_loader.sv
// rtl/clause_init_loader.sv - loads clause memory into enabled BCP engines; INIT_CHECKSUM_EN adds XOR checksum
module clause_init_loader
    import sat_init_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int N_ENG = 4,
    parameter int LAW   = $clog2(DEPTH),
    parameter int MAW   = $clog2(DEPTH * N_ENG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_ENG-1:0] eng_mask,
    output logic             mem_rd_en,
    output logic [MAW-1:0]   mem_addr,
    input  logic [W-1:0]     mem_rdata,
    output logic [N_ENG-1:0] eng_we,
    output logic [LAW-1:0]   eng_addr,
    output logic [W-1:0]     eng_wd,
    input  logic [N_ENG-1:0] eng_rdy,
`ifdef INIT_CHECKSUM_EN
    input  logic [W-1:0]     exp_sum,
    output logic [W-1:0]     sum,
    output logic             sum_err,
`endif
    output logic             busy,
    output logic             done
);
    localparam int EIW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

    init_state_e      state_q, state_d;
    logic [N_ENG-1:0] mask_q, mask_d;
    logic [EIW-1:0]   eng_idx_q, eng_idx_d;
    logic [LAW-1:0]   word_idx_q, word_idx_d;
    logic [W-1:0]     wd_q, wd_d;
`ifdef INIT_CHECKSUM_EN
    logic [W-1:0]     sum_q, sum_d;
    logic             sum_err_q, sum_err_d;
`endif

    logic [N_ENG-1:0] sel_mask;
    logic             nxt_found;
    logic [EIW-1:0]   nxt_idx;

    // In IDLE the finder looks at the live mask to pick the first engine of a new load.
    assign sel_mask = (state_q == ST_IDLE) ? eng_mask : mask_q;

    prio_next_sel #(
        .N_ENG (N_ENG),
        .IDXW  (EIW)
    ) u_sel (
        .mask_i       (sel_mask),
        .cur_i        (eng_idx_q),
        .from_start_i (state_q == ST_IDLE),
        .found_o      (nxt_found),
        .idx_o        (nxt_idx)
    );

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        eng_idx_d  = eng_idx_q;
        word_idx_d = word_idx_q;
        wd_d       = wd_q;
`ifdef INIT_CHECKSUM_EN
        sum_d      = sum_q;
        sum_err_d  = sum_err_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_d     = eng_mask;
                        word_idx_d = '0;
`ifdef INIT_CHECKSUM_EN
                        sum_d      = '0;
                        sum_err_d  = 1'b0;
`endif
                        if (nxt_found) begin
                            eng_idx_d = nxt_idx;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d   = ST_DONE;
                        end
                    end
                end
                ST_FETCH: state_d = ST_LATCH;
                ST_LATCH: begin
                    wd_d    = mem_rdata;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (eng_rdy[eng_idx_q]) begin
`ifdef INIT_CHECKSUM_EN
                        sum_d = sum_q ^ wd_q;
`endif
                        if (word_idx_q != LAW'(DEPTH - 1)) begin
                            word_idx_d = word_idx_q + LAW'(1);
                            state_d    = ST_FETCH;
                        end else if (nxt_found) begin
                            eng_idx_d  = nxt_idx;
                            word_idx_d = '0;
                            state_d    = ST_FETCH;
                        end else begin
                            state_d    = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
`ifdef INIT_CHECKSUM_EN
                    sum_err_d = (sum_q != exp_sum);
`endif
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            eng_idx_q  <= '0;
            word_idx_q <= '0;
            wd_q       <= '0;
`ifdef INIT_CHECKSUM_EN
            sum_q      <= '0;
            sum_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            eng_idx_q  <= eng_idx_d;
            word_idx_q <= word_idx_d;
            wd_q       <= wd_d;
`ifdef INIT_CHECKSUM_EN
            sum_q      <= sum_d;
            sum_err_q  <= sum_err_d;
`endif
        end
    end

    // Address/data buses are forced to zero outside the state that uses them.
    always_comb begin
        mem_rd_en = (state_q == ST_FETCH);
        mem_addr  = (state_q == ST_FETCH) ? MAW'({eng_idx_q, word_idx_q}) : '0;
        eng_we    = (state_q == ST_WRITE) ? (N_ENG'(1) << eng_idx_q) : '0;
        eng_addr  = (state_q == ST_WRITE) ? word_idx_q : '0;
        eng_wd    = (state_q == ST_WRITE) ? wd_q : '0;
        busy      = (state_q == ST_FETCH) || (state_q == ST_LATCH) || (state_q == ST_WRITE);
        done      = (state_q == ST_DONE);
    end

`ifdef INIT_CHECKSUM_EN
    assign sum     = sum_q;
    assign sum_err = sum_err_q;
`endif

endmodule

// File: doc/clause_init_loader.md
# clause_init_loader

- Parametrised successor to the fixed 3-bit-address initial controller.
- Sequences the clause memory into N_ENG BCP engines after reset or on demand: walks every word of every enabled engine and issues one write per word to the owning engine's local store.
- Observes per-engine backpressure and signals completion.
- Sits between `data_mem` and the `gen_bcp` array, ahead of the solver's first decision.

## Interface
- W, 8, clause word width
- DEPTH, 8, words per engine; power of two, ≥2
- N_ENG, 4, number of BCP engines; ≥1
- LAW, $clog2(DEPTH), engine-local address width (derived)
- MAW, $clog2(DEPTH*N_ENG), memory address width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin load; sampled in IDLE only
- abort  in  1  return to IDLE from any state; no done pulse
- eng_mask  in  N_ENG  engines to load; sampled on accepted start
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  MAW  memory word address
- mem_rdata  in  W  memory data, valid exactly 1 cycle after mem_rd_en
- eng_we  out  N_ENG  one-hot write strobe
- eng_addr  out  LAW  engine-local address
- eng_wd  out  W  write data
- eng_rdy  in  N_ENG  engine can accept a write
- busy  out  1  high in FETCH/LATCH/WRITE
- done  out  1  one-cycle pulse when the last enabled word is accepted

## Operation
- States: IDLE, FETCH, LATCH, WRITE, DONE.
- **IDLE:**
  - On start=1: capture eng_mask into mask_q.
  - Set eng_idx to the lowest set bit and word_idx=0, then go to FETCH.
  - If mask_q is all zero, go straight to DONE.
- **FETCH:** mem_rd_en=1, mem_addr={eng_idx, word_idx}; go to LATCH.
- **LATCH:** register mem_rdata into wd_q; go to WRITE.
- **WRITE:**
  - Drive eng_we[eng_idx]=1, eng_addr=word_idx, eng_wd=wd_q.
  - Transfer completes in a cycle where eng_rdy[eng_idx]=1; otherwise hold all outputs stable.
  - On transfer:
    - If word_idx < DEPTH-1: increment word_idx, go to FETCH.
    - Else if a higher enabled engine exists: jump eng_idx to it, word_idx=0, go to FETCH.
    - Else go to DONE.
- **DONE:** done=1 for one cycle; go to IDLE.
- abort=1 in any state forces IDLE next cycle and clears all strobes. It has priority over start and over a completing transfer.
- start while busy is ignored. eng_mask changes while busy are ignored.
- Disabled engines are skipped entirely and never receive eng_we.
- eng_rdy bits of engines other than eng_idx are don't-care.

## Timing
- Reset (rst=0 at an edge): state=IDLE.
  - Outputs: mem_rd_en=0, mem_addr=0, eng_we=0, eng_addr=0, eng_wd=0, busy=0, done=0.
  - Internal: mask_q=0, wd_q=0.
- Reset mid-load discards progress with no done pulse.
- start at edge k: mem_rd_en=1 during cycle k+1; first eng_we during cycle k+3.
- Throughput with eng_rdy held high: one write per 3 cycles.
  - Full load of E enabled engines: done asserted at cycle k + 3·E·DEPTH + 1.
- All outputs are registered or decoded from registered state only. No combinational path from eng_rdy or start to any output.
- eng_we is never asserted in the same cycle as done.

## Configuration
- INIT_CHECKSUM_EN defined:
  - Adds input exp_sum[W-1:0] and outputs sum[W-1:0], sum_err.
  - sum is the XOR of every accepted eng_wd word. It is cleared on accepted start and on reset.
  - sum_err is registered in DONE as (sum != exp_sum) and held until the next accepted start or reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package `sat_init_pkg`:
  - state enum `init_state_e`
  - helper function `next_enabled(mask, idx)` returning the next set bit above idx plus a found flag
- One sub-module, `prio_next_sel`: parametrised N_ENG next-set-bit finder used at start and at engine roll-over.
- Everything else is in a single always_ff FSM/datapath with a small always_comb output decode.

## Test plan
- **Full load:** reset, mask=4'b1111, eng_rdy=all 1, memory word a = a^8'h5A.
  - 32 writes, each with eng_addr=a%8 and engine a/8.
  - done at start+97.
- **Sparse mask:** mask=4'b1010. Only engines 1 and 3 written, mem_addr 8..15 then 24..31; done at start+49.
- **Zero mask:** mask=0. No mem_rd_en, no eng_we; done pulses at start+1.
- **Backpressure:** eng_rdy[0] low for 5 cycles at word 3.
  - eng_we, eng_addr=3 and eng_wd hold stable.
  - Write completes on the rdy cycle; done is delayed by exactly 5.
- **Abort/reset mid-load:** abort at word 10 gives IDLE with no done. A new start reloads from word 0. rst=0 during WRITE clears all outputs at the next edge.
- **Checksum (INIT_CHECKSUM_EN):** after the full load, sum=XOR of all 32 words.
  - exp_sum equal: sum_err=0.
  - exp_sum off by 1: sum_err=1.
